regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 33 +++
 rtl/regfile_wb_arbiter_if.sv | 39 +++
 rtl/regfile_wb_arbiter_rr_arbiter2.sv | 48 ++++
 rtl/regfile_wb_arbiter.sv | 93 +++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_pkg
// Description : Shared widths, port encoding and helpers for the writeback
//               arbiter and its register-file scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int DATA_W       = 32;
    localparam int NUM_REGS     = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
    localparam int WB_NUM_PORTS = 2;

    typedef enum logic [0:0] {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } wb_port_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] idx);
        logic [NUM_REGS-1:0] one;
        one = {{(NUM_REGS-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Writeback requester, allocation and register-file write
//               signals of the writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic                  p0_valid;
    logic [REG_ADDR_W-1:0] p0_rd;
    logic [DATA_W-1:0]     p0_data;
    logic                  p0_ready;
    logic                  p1_valid;
    logic [REG_ADDR_W-1:0] p1_rd;
    logic [DATA_W-1:0]     p1_data;
    logic                  p1_ready;
    logic                  alloc_valid;
    logic [REG_ADDR_W-1:0] alloc_reg;
    logic                  reg_wren;
    logic [REG_ADDR_W-1:0] w_reg0;
    logic [DATA_W-1:0]     w_data;
    logic [NUM_REGS-1:0]   busy;

    modport master (
        output p0_valid, p0_rd, p0_data, p1_valid, p1_rd, p1_data,
        output alloc_valid, alloc_reg,
        input  p0_ready, p1_ready, reg_wren, w_reg0, w_data, busy
    );

    modport slave (
        input  p0_valid, p0_rd, p0_data, p1_valid, p1_rd, p1_data,
        input  alloc_valid, alloc_reg,
        output p0_ready, p1_ready, reg_wren, w_reg0, w_data, busy
    );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-input combinational grant with round-robin or fixed
//               (port 0 first) priority; history moves only on a transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int PRIO_FIXED = 0
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic [1:0] req,
    input  wire logic       advance,
    output logic      [1:0] grant
);

    wb_port_e r_last_grant;

    // Reset to port 1 so port 0 wins the first contest.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= PORT1;
        end else if (advance) begin
            r_last_grant <= grant[1] ? PORT1 : PORT0;
        end
    end

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if ((PRIO_FIXED != 0) || (r_last_grant == PORT1)) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Arbitrates ALU/load writebacks onto one registered register
//               file write port and tracks outstanding writes per register.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int PRIO_FIXED = 0
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    regfile_wb_arbiter_if.slave  bus
);

    logic [1:0]            w_req;
    logic [1:0]            w_grant;
    logic [1:0]            w_ready;
    logic                  w_xfer;
    logic                  w_write;
    wb_req_t               w_sel;
    logic [NUM_REGS-1:0]   w_commit_clr;
    logic [NUM_REGS-1:0]   w_alloc_set;

    logic                  r_reg_wren;
    logic [REG_ADDR_W-1:0] r_w_reg0;
    logic [DATA_W-1:0]     r_w_data;
    logic [NUM_REGS-1:0]   r_busy;

    assign w_req = {bus.p1_valid, bus.p0_valid};

    rr_arbiter2 #(
        .PRIO_FIXED (PRIO_FIXED)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (w_req),
        .advance (w_xfer),
        .grant   (w_grant)
    );

    // No handshake may complete while reset is held.
    assign w_ready      = w_grant & {2{reset_n}};
    assign w_xfer       = |w_ready;
    assign bus.p0_ready = w_ready[0];
    assign bus.p1_ready = w_ready[1];

    always_comb begin
        w_sel = '{rd: bus.p0_rd, data: bus.p0_data};
        if (w_ready[1]) begin
            w_sel = '{rd: bus.p1_rd, data: bus.p1_data};
        end
    end

    // r0 is hardwired zero: handshake completes but nothing is written.
    assign w_write = w_xfer && (w_sel.rd != ZERO_REG);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reg_wren <= 1'b0;
            r_w_reg0   <= '0;
            r_w_data   <= '0;
        end else begin
            r_reg_wren <= w_write;
            if (w_write) begin
                r_w_reg0 <= w_sel.rd;
                r_w_data <= w_sel.data;
            end
        end
    end

    assign w_commit_clr = r_reg_wren ? reg_onehot(r_w_reg0) : '0;
    assign w_alloc_set  = (bus.alloc_valid && (bus.alloc_reg != ZERO_REG))
                          ? reg_onehot(bus.alloc_reg) : '0;

    // Set after clear so a same-cycle alloc of a committing register wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_commit_clr) | w_alloc_set) & ~reg_onehot(ZERO_REG);
        end
    end

    assign bus.reg_wren = r_reg_wren;
    assign bus.w_reg0   = r_w_reg0;
    assign bus.w_data   = r_w_data;
    assign bus.busy     = r_busy;

endmodule
`default_nettype wire
